demux1to4_stream: RTL and testbench
===================================

# demux1to4_stream

Registered 1-to-4 stream demultiplexer: it accepts one valid/ready input stream and routes each beat to one of four valid/ready output channels. Within a packet it holds the routing decision, so a multi-beat packet is never split across outputs. It is the distribution-side counterpart of the 4-to-1 mux blocks: it fans a shared stream out to four consumers, while the mux blocks merge four sources into one.

## Interface
Parameters:
- WIDTH, 8, data width per beat

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid && in_ready
- in_data  input  WIDTH  input payload
- in_sel  input  2  destination channel; sampled on the first beat of a packet only
- in_last  input  1  final beat of packet
- out_valid  output  4  per-channel beat present
- out_ready  input  4  per-channel consumer ready
- out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_last  output  4  per-channel last flag
- busy  output  1  high while a packet is open (state PKT)
- route  output  2  current routing channel (in_sel in IDLE, latched select in PKT)

## Operation
- FSM, two states:
  - IDLE (reset state): route = in_sel.
  - PKT: route = latched route_q; in_sel is ignored.
- IDLE -> PKT on an accepted beat with in_last=0; route_q <= in_sel on that beat.
- PKT -> IDLE on an accepted beat with in_last=1.
- An accepted single-beat packet (in_last=1 in IDLE) stays in IDLE.
- Each channel has a one-entry output slice holding data, last and valid.
  - A slice is free when !out_valid[k] || out_ready[k].
- in_ready = slice[route] free. in_ready is combinational from out_ready[route] and route.
- Accepted beat: slice[route] loads in_data and in_last, and its valid is set.
- Slice k drains when out_valid[k] && out_ready[k]. Its valid clears unless it reloads in the same cycle.
- Non-routed channels are unaffected by input activity and drain independently.
- While a slice is stalled, its out_data[k] and out_last[k] are held stable.
- in_valid=0 causes no state change.
- in_data, in_sel and in_last are don't-care when in_valid=0.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - out_valid = 4'b0000, out_data = 0, out_last = 0
  - state = IDLE, route_q = 0, busy = 0
- in_ready is low during reset.
- Latency: a beat accepted in cycle N appears on out_valid[route] in cycle N+1.
- Throughput: 1 beat/cycle per channel when out_ready[route] is held high. A simultaneous drain and load on the same slice is allowed with no bubble.
- Backpressure: with out_valid[route]=1 and out_ready[route]=0, in_ready=0 and nothing is accepted.
- Reset mid-packet: the open packet is abandoned and beats in the slices are discarded. After rst_n rises, the first accepted beat is treated as a new packet head.
- Simultaneous events: route changes only on the clock edge after an accepted in_last beat. A head beat for a new channel may be accepted in the cycle right after the previous packet's last beat.

## Structure
- Shared include header: state encodings (ST_IDLE=1'b0, ST_PKT=1'b1), N_CH=4, SEL_W=2.
- Sub-module demux_out_slice: one-entry valid/ready register with WIDTH+1 bits (data+last), load and drain logic. Instantiated 4 times.
- The top level holds the FSM, route_q, the in_ready select and the load-enable decode (one-hot of route, gated by the accept condition).

## Test plan
- Single beats: in_sel=0..3, data 8'hA0..8'hA3, in_last=1, all out_ready=1 -> each value appears on its channel one cycle later, other out_valid=0, busy stays 0.
- Packet hold: 3-beat packet 8'h11/12/13 with in_sel=2 on the head, in_sel changed to 1 on beats 2-3 -> all three beats on channel 2, busy=1 from after beat 1 until after beat 3, route=2 throughout.
- Backpressure: out_ready[1]=0, send 2 beats to channel 1 -> first beat is held stable in slice 1, in_ready=0, second beat stalls. Raise out_ready[1] -> both beats delivered in order, no loss or duplication.
- Independence: channel 0 stalled holding 8'h55 while a packet is sent to channel 3 -> channel 3 receives at full rate and channel 0 data is unchanged.
- Back-to-back packets: last beat to channel 0 immediately followed by a head beat to channel 2 -> both accepted on consecutive cycles, correct routing.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 3-beat packet -> all out_valid=0 and busy=0 immediately. After release, the next beat routes by its own in_sel.

Source files
------------

// File: rtl/demux1to4_stream_pkg.sv
// demux1to4_stream shared types
// State encoding and channel geometry
package demux1to4_stream_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_out_slice.sv
// demux1to4_stream output register slice
// One-entry valid/ready holding register
module demux_out_slice #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic         free,
  output logic [W-1:0] q
);

  assign free = !valid || ready;

  // load wins over drain so a full-rate stream has no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_stream.sv
// demux1to4_stream top
// Packet-aware 1-to-4 valid/ready demultiplexer
module demux1to4_stream
  import demux1to4_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_last,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_last,
  output logic               busy,
  output logic [1:0]         route
);

  state_t             state;
  logic [SEL_W-1:0]   route_q;
  logic [N_CH-1:0]    free;
  logic [N_CH-1:0]    load;
  logic               accept;
  logic [WIDTH:0]     sq [N_CH];

  assign route    = (state == ST_PKT) ? route_q : in_sel;
  assign in_ready = rst_n && free[route];
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_PKT);

  // one-hot load enable for the routed slice
  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept && (route == SEL_W'(k));
    end
  end

  // packet framing: hold the head's select until the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      route_q <= '0;
    end else if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (!in_last) begin
            state   <= ST_PKT;
            route_q <= in_sel;
          end
        end
        ST_PKT: begin
          if (in_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux_out_slice #(
      .W(WIDTH + 1)
    ) u_slice (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[k]),
      .d    ({in_last, in_data}),
      .ready(out_ready[k]),
      .valid(out_valid[k]),
      .free (free[k]),
      .q    (sq[k])
    );
    assign out_data[k*WIDTH +: WIDTH] = sq[k][WIDTH-1:0];
    assign out_last[k]                = sq[k][WIDTH];
  end

endmodule

// File: tb/tb_demux1to4_stream.sv
// demux1to4_stream testbench
// Directed scenarios plus random traffic vs queue model
module tb_demux1to4_stream;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_last;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_last;
  logic           busy;
  logic [1:0]     route;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t      mq [4][$];
  bit         open = 1'b0;
  logic [1:0] ch   = 2'd0;

  always #5 clk = ~clk;

  demux1to4_stream #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .route    (route)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(bit v, logic [W-1:0] d, logic [1:0] s,
                     bit l, logic [3:0] r);
    logic [1:0] rt;
    bit         rdy;
    bit         acc;
    beat_t      b;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    in_last   = l;
    out_ready = r;
    #1;
    rt  = open ? ch : s;
    rdy = (mq[rt].size() == 0) || r[rt];
    acc = v && rdy;
    chk("in_ready", in_ready, rdy);
    chk("route", route, rt);
    chk("busy", busy, open);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k), out_valid[k], mq[k].size() != 0);
      if (mq[k].size() != 0) begin
        chk($sformatf("data%0d", k), out_data[k*W +: W], mq[k][0].d);
        chk($sformatf("last%0d", k), out_last[k], mq[k][0].l);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0 && r[k]) void'(mq[k].pop_front());
    end
    if (acc) begin
      b.d = d;
      b.l = l;
      mq[rt].push_back(b);
      if (!open && !l) begin
        open = 1'b1;
        ch   = s;
      end else if (open && l) begin
        open = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_data", out_data, '0);
    chk("rst_last", out_last, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    for (int k = 0; k < 4; k++) mq[k].delete();
    open = 1'b0;
    ch   = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_last   = 1'b0;
    out_ready = 4'hF;
    do_reset();

    // single-beat packets to each channel
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'hA0 + W'(i), 2'(i), 1'b1, 4'hF);
    end
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // packet hold: select changes mid-packet are ignored
    cyc(1'b1, 8'h11, 2'd2, 1'b0, 4'hF);
    cyc(1'b1, 8'h12, 2'd1, 1'b0, 4'hF);
    cyc(1'b1, 8'h13, 2'd1, 1'b1, 4'hF);
    cyc(1'b0, 8'h00, 2'd1, 1'b0, 4'hF);

    // backpressure on channel 1
    cyc(1'b1, 8'h21, 2'd1, 1'b1, 4'b1101);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h22, 2'd1, 1'b1, 4'b1101);
    cyc(1'b1, 8'h22, 2'd1, 1'b1, 4'hF);
    cyc(1'b0, 8'h00, 2'd1, 1'b0, 4'hF);
    cyc(1'b0, 8'h00, 2'd1, 1'b0, 4'hF);

    // channel 0 stalled while channel 3 streams
    cyc(1'b1, 8'h55, 2'd0, 1'b1, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h60 + W'(i), 2'd3, i == 3, 4'b1110);
    end
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'b1110);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // back-to-back packets to different channels
    cyc(1'b1, 8'h31, 2'd0, 1'b0, 4'hF);
    cyc(1'b1, 8'h32, 2'd3, 1'b1, 4'hF);
    cyc(1'b1, 8'h33, 2'd2, 1'b1, 4'hF);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // reset in the middle of a packet
    cyc(1'b1, 8'h41, 2'd3, 1'b0, 4'b0000);
    do_reset();
    cyc(1'b1, 8'h42, 2'd1, 1'b1, 4'hF);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), W'($urandom),
          2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
          4'($urandom));
    end

    // drain everything and confirm nothing is left
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), out_valid[k], 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
